// File: rtl/contador_estacionamiento.sv
// Parking-lot occupancy counter: decodes the two-barrier sensor sequence
// into entry/exit events and keeps a saturating vehicle count.
module contador_estacionamiento #(
  parameter int CAPACIDAD = 15,
  parameter int ANCHO     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sen_a,
  input  logic             sen_b,
  output logic             entrada,
  output logic             salida,
  output logic             error,
  output logic [ANCHO-1:0] ocupacion,
  output logic             lleno,
  output logic             vacio
);

  localparam logic [ANCHO-1:0] CAP  = ANCHO'(CAPACIDAD);
  localparam logic [ANCHO-1:0] CERO = '0;
  localparam logic [ANCHO-1:0] UNO  = {{(ANCHO-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    LIBRE  = 3'd0,
    ENT_A  = 3'd1,
    ENT_AB = 3'd2,
    ENT_B  = 3'd3,
    SAL_B  = 3'd4,
    SAL_BA = 3'd5,
    SAL_A  = 3'd6,
    ESPERA = 3'd7
  } estado_t;

  estado_t          estado_reg, estado_next;
  logic             evento_ent, evento_sal, error_sec;
  logic [ANCHO-1:0] ocupacion_next;
  logic             entrada_next, salida_next, error_next;
  logic [1:0]       ab;

  assign ab = {sen_a, sen_b};

  always_comb begin
    estado_next = estado_reg;
    evento_ent  = 1'b0;
    evento_sal  = 1'b0;
    error_sec   = 1'b0;
    case (estado_reg)
      LIBRE: begin
        case (ab)
          2'b10:   estado_next = ENT_A;
          2'b01:   estado_next = SAL_B;
          2'b11: begin estado_next = ESPERA; error_sec = 1'b1; end
          default: estado_next = LIBRE;
        endcase
      end
      ENT_A: begin
        case (ab)
          2'b10:   estado_next = ENT_A;
          2'b11:   estado_next = ENT_AB;
          2'b00:   estado_next = LIBRE;
          default: begin estado_next = ESPERA; error_sec = 1'b1; end
        endcase
      end
      ENT_AB: begin
        case (ab)
          2'b11:   estado_next = ENT_AB;
          2'b01:   estado_next = ENT_B;
          2'b10:   estado_next = ENT_A;
          default: begin estado_next = ESPERA; error_sec = 1'b1; end
        endcase
      end
      ENT_B: begin
        case (ab)
          2'b01:   estado_next = ENT_B;
          2'b11:   estado_next = ENT_AB;
          2'b00: begin estado_next = LIBRE; evento_ent = 1'b1; end
          default: begin estado_next = ESPERA; error_sec = 1'b1; end
        endcase
      end
      SAL_B: begin
        case (ab)
          2'b01:   estado_next = SAL_B;
          2'b11:   estado_next = SAL_BA;
          2'b00:   estado_next = LIBRE;
          default: begin estado_next = ESPERA; error_sec = 1'b1; end
        endcase
      end
      SAL_BA: begin
        case (ab)
          2'b11:   estado_next = SAL_BA;
          2'b10:   estado_next = SAL_A;
          2'b01:   estado_next = SAL_B;
          default: begin estado_next = ESPERA; error_sec = 1'b1; end
        endcase
      end
      SAL_A: begin
        case (ab)
          2'b10:   estado_next = SAL_A;
          2'b11:   estado_next = SAL_BA;
          2'b00: begin estado_next = LIBRE; evento_sal = 1'b1; end
          default: begin estado_next = ESPERA; error_sec = 1'b1; end
        endcase
      end
      ESPERA: begin
        if (ab == 2'b00) estado_next = LIBRE;
      end
      default: estado_next = LIBRE;
    endcase
  end

  // Events only fire on a return to LIBRE, so they are mutually exclusive
  // with sequence errors; a count violation turns the event into an error.
  always_comb begin
    ocupacion_next = ocupacion;
    entrada_next   = 1'b0;
    salida_next    = 1'b0;
    error_next     = error_sec;
    if (evento_ent) begin
      if (ocupacion < CAP) begin
        ocupacion_next = ocupacion + UNO;
        entrada_next   = 1'b1;
      end else begin
        error_next = 1'b1;
      end
    end else if (evento_sal) begin
      if (ocupacion > CERO) begin
        ocupacion_next = ocupacion - UNO;
        salida_next    = 1'b1;
      end else begin
        error_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_reg <= LIBRE;
      ocupacion  <= '0;
      entrada    <= 1'b0;
      salida     <= 1'b0;
      error      <= 1'b0;
    end else begin
      estado_reg <= estado_next;
      ocupacion  <= ocupacion_next;
      entrada    <= entrada_next;
      salida     <= salida_next;
      error      <= error_next;
    end
  end

  assign lleno = (ocupacion == CAP);
  assign vacio = (ocupacion == CERO);

endmodule

// File: tb/tb_contador_estacionamiento.sv
// Bench for contador_estacionamiento (CAPACIDAD=3): scenario tasks queue the
// expected per-cycle outputs and compare them as the DUT produces them.
module tb_contador_estacionamiento;

  localparam int CAPACIDAD = 3;
  localparam int ANCHO     = 4;
  localparam int EV_NO  = 0;
  localparam int EV_ENT = 1;
  localparam int EV_SAL = 2;
  localparam int EV_ERR = 3;

  typedef struct packed {
    logic             ent;
    logic             sal;
    logic             err;
    logic [ANCHO-1:0] ocup;
  } esperado_t;

  logic             clk;
  logic             reset;
  logic             sen_a;
  logic             sen_b;
  logic             entrada;
  logic             salida;
  logic             error;
  logic [ANCHO-1:0] ocupacion;
  logic             lleno;
  logic             vacio;

  esperado_t  cola[$];
  int         exp_ocup;
  int         n_comp;
  int         n_fail;

  contador_estacionamiento #(.CAPACIDAD(CAPACIDAD), .ANCHO(ANCHO)) dut (
    .clk       (clk),
    .reset     (reset),
    .sen_a     (sen_a),
    .sen_b     (sen_b),
    .entrada   (entrada),
    .salida    (salida),
    .error     (error),
    .ocupacion (ocupacion),
    .lleno     (lleno),
    .vacio     (vacio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold {a,b} for 3 cycles; ev is the pulse expected after the first edge.
  task automatic paso(input logic a, input logic b, input int ev, input string nombre);
    esperado_t e;
    logic      exp_lleno, exp_vacio;
    sen_a = a;
    sen_b = b;
    for (int i = 0; i < 3; i++) begin
      e = '0;
      if (i == 0) begin
        case (ev)
          EV_ENT: begin e.ent = 1'b1; exp_ocup = exp_ocup + 1; end
          EV_SAL: begin e.sal = 1'b1; exp_ocup = exp_ocup - 1; end
          EV_ERR: e.err = 1'b1;
          default: ;
        endcase
      end
      e.ocup = ANCHO'(exp_ocup);
      cola.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      e = cola.pop_front();
      exp_lleno = (e.ocup == ANCHO'(CAPACIDAD));
      exp_vacio = (e.ocup == '0);
      n_comp++;
      if ({entrada, salida, error, ocupacion} !== {e.ent, e.sal, e.err, e.ocup}) begin
        n_fail++;
        $display("FAIL %s ab=%b%b cyc%0d: got ent=%b sal=%b err=%b ocup=%0d, want ent=%b sal=%b err=%b ocup=%0d",
                 nombre, a, b, i, entrada, salida, error, ocupacion, e.ent, e.sal, e.err, e.ocup);
      end
      n_comp++;
      if ({lleno, vacio} !== {exp_lleno, exp_vacio}) begin
        n_fail++;
        $display("FAIL %s flags cyc%0d: got lleno=%b vacio=%b, want lleno=%b vacio=%b",
                 nombre, i, lleno, vacio, exp_lleno, exp_vacio);
      end
    end
    $display("paso %-12s ab=%b%b ev=%0d ocup=%0d", nombre, a, b, ev, ocupacion);
  endtask

  task automatic entrar(input int ev_final, input string nombre);
    paso(1'b1, 1'b0, EV_NO, nombre);
    paso(1'b1, 1'b1, EV_NO, nombre);
    paso(1'b0, 1'b1, EV_NO, nombre);
    paso(1'b0, 1'b0, ev_final, nombre);
  endtask

  task automatic salir(input int ev_final, input string nombre);
    paso(1'b0, 1'b1, EV_NO, nombre);
    paso(1'b1, 1'b1, EV_NO, nombre);
    paso(1'b1, 1'b0, EV_NO, nombre);
    paso(1'b0, 1'b0, ev_final, nombre);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sen_a = 1'b0;
    sen_b = 1'b0;
    exp_ocup = 0;
    repeat (2) @(posedge clk);
    #1;
    n_comp++;
    if ({entrada, salida, error, ocupacion, lleno, vacio} !== {3'b000, 4'd0, 2'b01}) begin
      n_fail++;
      $display("FAIL reset: got ent=%b sal=%b err=%b ocup=%0d lleno=%b vacio=%b, want 0 0 0 0 0 1",
               entrada, salida, error, ocupacion, lleno, vacio);
    end
    @(negedge clk);
    reset = 1'b1;
    paso(1'b0, 1'b0, EV_NO, "reset_idle");
  endtask

  task automatic test_entrada();
    entrar(EV_ENT, "entrada");
  endtask

  task automatic test_salida();
    salir(EV_SAL, "salida");
  endtask

  task automatic test_lleno();
    entrar(EV_ENT, "lleno_1");
    entrar(EV_ENT, "lleno_2");
    entrar(EV_ENT, "lleno_3");
    entrar(EV_ERR, "lleno_4");
  endtask

  task automatic test_retroceso();
    paso(1'b1, 1'b0, EV_NO, "retroceso");
    paso(1'b1, 1'b1, EV_NO, "retroceso");
    paso(1'b1, 1'b0, EV_NO, "retroceso");
    paso(1'b0, 1'b0, EV_NO, "retroceso");
  endtask

  task automatic test_error_secuencia();
    paso(1'b1, 1'b0, EV_NO,  "err_seq");
    paso(1'b0, 1'b1, EV_ERR, "err_seq");
    paso(1'b1, 1'b1, EV_NO,  "err_seq");
    paso(1'b0, 1'b0, EV_NO,  "err_seq");
    salir(EV_SAL, "post_err");
  endtask

  task automatic test_reset_medio();
    paso(1'b1, 1'b0, EV_NO, "rst_medio");
    paso(1'b1, 1'b1, EV_NO, "rst_medio");
    paso(1'b0, 1'b1, EV_NO, "rst_medio");
    #2;
    reset = 1'b0;
    #1;
    exp_ocup = 0;
    n_comp++;
    if ({entrada, salida, error, ocupacion, vacio} !== {3'b000, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_async: got ent=%b sal=%b err=%b ocup=%0d vacio=%b, want 0 0 0 0 1",
               entrada, salida, error, ocupacion, vacio);
    end
    @(posedge clk);
    #1;
    n_comp++;
    if ({entrada, ocupacion} !== {1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL rst_hold: got ent=%b ocup=%0d, want ent=0 ocup=0", entrada, ocupacion);
    end
    @(negedge clk);
    sen_a = 1'b0;
    sen_b = 1'b0;
    reset = 1'b1;
    paso(1'b0, 1'b0, EV_NO, "rst_release");
  endtask

  task automatic test_back_to_back();
    entrar(EV_ENT, "b2b_ent");
    salir(EV_SAL, "b2b_sal");
    salir(EV_ERR, "sal_vacio");
    paso(1'b1, 1'b1, EV_ERR, "libre_11");
    paso(1'b0, 1'b0, EV_NO,  "libre_11");
    entrar(EV_ENT, "tras_err");
  endtask

  initial begin
    n_comp = 0;
    n_fail = 0;
    test_reset();
    test_entrada();
    test_salida();
    test_lleno();
    test_retroceso();
    test_error_secuencia();
    test_reset_medio();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
    $finish;
  end

endmodule
